// File: rtl/arith_pkg.sv
// arith_pkg: shared types and constants for the arithmetic unit
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Quotient reported for a zero divisor; users slice the low WIDTH bits.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/cla_addsub_core.sv
// cla_addsub_core: W-bit carry-lookahead adder/subtractor (sel=1 subtracts b)
module cla_addsub_core #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] sum,
    output logic         c_out
);

    logic [W-1:0] bx;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;

    assign bx = b ^ {W{sel}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    // Each carry is formed directly from generate/propagate terms and the carry-in.
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = sel;
        for (int i = 1; i <= W; i++) begin
            term = sel;
            for (int k = 0; k < i; k++) term = term & p[k];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
    end

    assign sum   = p ^ c[W-1:0];
    assign c_out = c[W];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider producing one quotient bit per clock
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t;
    logic             no_borrow;
    logic [WIDTH:0]   r_nxt;
    logic [WIDTH-1:0] q_nxt;

    assign r_shift = {r[WIDTH-1:0], q[WIDTH-1]};

    cla_addsub_core #(.W(WIDTH + 1)) u_addsub (
        .a     (r_shift),
        .b     ({1'b0, d}),
        .sel   (1'b1),
        .sum   (t),
        .c_out (no_borrow)
    );

    assign r_nxt = no_borrow ? t : r_shift;
    assign q_nxt = {q[WIDTH-2:0], no_borrow};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ready     = (state == IDLE);
        busy      = (state == RUN) || (state == DONE);
        done      = (state == DONE);
        case (state)
            IDLE:    state_nxt = start ? ((divisor == '0) ? DONE : RUN) : IDLE;
            RUN:     state_nxt = (count == '0) ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift/subtract iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            r           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            d           <= divisor;
            q           <= dividend;
            r           <= '0;
            count       <= CW'(WIDTH - 1);
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
                quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            q <= q_nxt;
            r <= r_nxt;
            if (count == '0) begin
                quotient  <= q_nxt;
                remainder <= r_nxt[WIDTH-1:0];
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and sweep checks of seq_divider against a quotient/remainder model
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int n_acc = 0;
    int n_done = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int model_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Scoreboard: remembers the accepted operands and checks every done pulse.
    bit pending = 0;
    int lat = 0;
    int eq, er, edz, elat;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 0;
        end else begin
            if (pending) lat++;
            if (done) begin
                n_done++;
                chk("done_expected", int'(pending), 1);
                chk("ready_in_done", int'(ready), 0);
                chk("busy_in_done", int'(busy), 1);
                if (pending) begin
                    chk("sb_quotient", int'(quotient), eq);
                    chk("sb_remainder", int'(remainder), er);
                    chk("sb_dbz", int'(div_by_zero), edz);
                    chk("sb_latency", lat, elat);
                end
                pending = 0;
            end else if (pending && lat > W + 4) begin
                chk("sb_timeout", lat, elat);
                pending = 0;
            end
            chk("ready_vs_busy", int'(ready), int'(!busy));
            if (ready && start) begin
                pending = 1;
                lat = 0;
                eq = model_q(int'(dividend), int'(divisor));
                er = model_r(int'(dividend), int'(divisor));
                edz = (divisor == '0) ? 1 : 0;
                elat = (divisor == '0) ? 1 : W + 1;
                n_acc++;
            end
        end
    end

    task automatic wait_done(output bit got);
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_seen", int'(got), 1);
    endtask

    task automatic run_div(input int a, input int b, input int xq, input int xr, input int xdz);
        bit got;
        @(posedge clk); #1;
        dividend = W'(a);
        divisor = W'(b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(got);
        if (got) begin
            chk("quotient", int'(quotient), xq);
            chk("remainder", int'(remainder), xr);
            chk("dbz", int'(div_by_zero), xdz);
        end
    endtask

    initial begin
        bit got;
        int acc0;
        #12;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_div(13, 3, 4, 1, 0);
        run_div(7, 0, 15, 7, 1);
        run_div(15, 1, 15, 0, 0);
        run_div(3, 5, 0, 3, 0);
        run_div(0, 9, 0, 0, 0);
        run_div(15, 15, 1, 0, 0);

        // Second start during RUN must be ignored.
        @(posedge clk); #1;
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dividend = 4'd5; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(got);
        if (got) begin
            chk("ignored_q", int'(quotient), 4);
            chk("ignored_r", int'(remainder), 2);
        end

        // Start held high: only accepted when ready.
        @(posedge clk); #1;
        acc0 = n_acc;
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
        repeat (20) @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        chk("held_accepts", n_acc - acc0, 4);
        chk("held_q", int'(quotient), 4);
        chk("held_r", int'(remainder), 1);

        // Reset mid-RUN aborts and clears outputs.
        @(posedge clk); #1;
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 1'b0);
        chk("abort_dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        chk("abort_no_done", n_done, n_acc - 1);
        n_acc = n_done;
        run_div(12, 5, 2, 2, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_div(a, b, model_q(a, b), model_r(a, b), (b == 0) ? 1 : 0);

        repeat (3) @(posedge clk);
        chk("done_per_start", n_done, n_acc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
